// File: rtl/alu_pipe_if.sv
// Operand-issue and result-writeback handshake bundle for alu_pipe.
// The master side drives operands and consumes results; the slave side is the ALU.
interface alu_pipe_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       in_opcode;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_cout;
    logic             out_of;
    logic             out_zero;
    logic             out_err;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_opcode, in_cin, out_ready,
        input  in_ready, out_valid, out_result, out_cout, out_of, out_zero, out_err, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_opcode, in_cin, out_ready,
        output in_ready, out_valid, out_result, out_cout, out_of, out_zero, out_err, busy
    );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides and an iterative shift-add multiplier.
// Single-cycle ops land in the output register on acceptance; MUL lands WIDTH cycles later.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input logic       clk,
    input logic       rst_n,
    alu_pipe_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);
    localparam logic [3:0] OP_MUL = 4'b1011;

    typedef enum logic {IDLE, MUL} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             cout;
        logic             of;
        logic             err;
    } res_t;

    function automatic res_t alu_op(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b, input logic cin);
        res_t                    r;
        logic [WIDTH:0]          sum;
        logic [SH_W-1:0]         sh;
        logic signed [WIDTH-1:0] a_s;
        logic signed [WIDTH-1:0] b_s;
        r   = '0;
        sum = '0;
        sh  = b[SH_W-1:0];
        a_s = a;
        b_s = b;
        case (op)
            4'b0000: r.result = a & b;
            4'b0001: r.result = a | b;
            4'b0010: r.result = a ^ b;
            4'b0011: r.result = ~a;
            4'b0100, 4'b0101: begin
                sum      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin & (op == 4'b0101)};
                r.result = sum[WIDTH-1:0];
                r.cout   = sum[WIDTH];
                r.of     = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0110: begin
                // cout here is the inverted borrow of A-B
                sum      = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                r.result = sum[WIDTH-1:0];
                r.cout   = sum[WIDTH];
                r.of     = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0111: r.result = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            4'b1000: r.result = a << sh;
            4'b1001: r.result = a >> sh;
            4'b1010: r.result = a_s >>> sh;
            4'b1100: r.result = b;
            4'b1101, 4'b1110, 4'b1111: r.err = 1'b1;
            default: ;
        endcase
        return r;
    endfunction

    state_t               state;
    state_t               state_nx;
    logic [SH_W-1:0]      cnt_p0;
    logic [2*WIDTH-1:0]   acc_p0;
    logic [2*WIDTH-1:0]   mcand_p0;
    logic [WIDTH-1:0]     mplier_p0;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     result_p1;
    logic                 cout_p1;
    logic                 of_p1;
    logic                 zero_p1;
    logic                 err_p1;
    logic                 vld_p1;
    logic                 accept;
    logic                 is_mul;
    logic                 load_single;
    logic                 mul_done;
    res_t                 alu_p0;

    assign bus.in_ready  = (state == IDLE) && (!vld_p1 || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign is_mul        = (bus.in_opcode == OP_MUL);
    assign load_single   = accept && !is_mul;
    assign mul_done      = (state == MUL) && (cnt_p0 == SH_W'(WIDTH - 1));
    assign acc_next      = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);

    always_comb begin
        alu_p0 = alu_op(bus.in_opcode, bus.in_a, bus.in_b, bus.in_cin);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && is_mul) state_nx = MUL;
            MUL:     if (mul_done)         state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Stage p0: multiplier iteration, one partial product per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0    <= '0;
            acc_p0    <= '0;
            mcand_p0  <= '0;
            mplier_p0 <= '0;
        end else if (accept && is_mul) begin
            cnt_p0    <= '0;
            acc_p0    <= '0;
            mcand_p0  <= {{WIDTH{1'b0}}, bus.in_a};
            mplier_p0 <= bus.in_b;
        end else if (state == MUL) begin
            cnt_p0    <= cnt_p0 + SH_W'(1);
            acc_p0    <= acc_next;
            mcand_p0  <= mcand_p0 << 1;
            mplier_p0 <= mplier_p0 >> 1;
        end
    end

    // Stage p1: output register, written only when it is free or being drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_p1 <= '0;
            cout_p1   <= 1'b0;
            of_p1     <= 1'b0;
            zero_p1   <= 1'b0;
            err_p1    <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            if (load_single) begin
                result_p1 <= alu_p0.result;
                cout_p1   <= alu_p0.cout;
                of_p1     <= alu_p0.of;
                zero_p1   <= (alu_p0.result == '0);
                err_p1    <= alu_p0.err;
            end else if (mul_done) begin
                result_p1 <= acc_next[WIDTH-1:0];
                cout_p1   <= |acc_next[2*WIDTH-1:WIDTH];
                of_p1     <= 1'b0;
                zero_p1   <= (acc_next[WIDTH-1:0] == '0);
                err_p1    <= 1'b0;
            end
            if (load_single || mul_done) vld_p1 <= 1'b1;
            else if (bus.out_ready)      vld_p1 <= 1'b0;
        end
    end

    assign bus.out_valid  = vld_p1;
    assign bus.out_result = result_p1;
    assign bus.out_cout   = cout_p1;
    assign bus.out_of     = of_p1;
    assign bus.out_zero   = zero_p1;
    assign bus.out_err    = err_p1;
    assign bus.busy       = (state == MUL);
endmodule
